// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches up/down hall presses into request slots and
// offers each pending call, one at a time, to the nearest idle car.
module hall_call_dispatcher #(
  parameter int FLOORS = 4,
  parameter int CARS   = 2,
  localparam int FB    = $clog2(FLOORS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLOORS-1:0]    hall_up,
  input  logic [FLOORS-1:0]    hall_down,
  input  logic [CARS*FB-1:0]   car_loc,
  input  logic [CARS-1:0]      car_idle,
  input  logic [CARS-1:0]      served_valid,
  input  logic [CARS*FB-1:0]   served_floor,
  input  logic [CARS-1:0]      served_dir,
  output logic                 asg_valid,
  output logic                 asg_car,
  output logic [FB-1:0]        asg_floor,
  output logic                 asg_dir,
  input  logic                 asg_ready,
  output logic [FLOORS-1:0]    lamp_up,
  output logic [FLOORS-1:0]    lamp_down
);
  localparam int NS = 2 * FLOORS;
  localparam int SB = FB + 1;

  typedef enum logic {SCAN, OFFER} state_t;

  state_t          state_reg, state_next;
  logic [SB-1:0]   ptr_reg;
  logic            rr_reg;
  logic [SB-1:0]   off_slot_reg;
  logic            asg_car_reg;

  logic [NS-1:0]   pend_vec, asgd_vec, served_hit, cand;
  logic            latch, accept;
  logic            found;
  logic [SB-1:0]   scan_slot, idx;
  logic [SB:0]     sum;
  logic [FB-1:0]   scan_floor;
  logic [FB:0]     loc0, loc1, tgt, dist0, dist1;
  logic            pick_car;

  // Slot f is "up at floor f", slot FLOORS+f is "down at floor f".
  for (genvar gi = 0; gi < NS; gi++) begin : g_slot
    localparam int FL    = gi % FLOORS;
    localparam bit DR    = (gi >= FLOORS);
    localparam bit VALID = DR ? (FL != 0) : (FL != FLOORS - 1);

    logic pend_reg, asgd_reg, hit, press;

    always_comb begin
      hit = 1'b0;
      for (int c = 0; c < CARS; c++) begin
        if (served_valid[c] && served_floor[c*FB +: FB] == FB'(FL) && served_dir[c] == DR)
          hit = 1'b1;
      end
    end

    assign press = VALID && (DR ? hall_down[FL] : hall_up[FL]);

    // Served has priority over both acceptance and a new press.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_reg <= 1'b0;
        asgd_reg <= 1'b0;
      end else if (hit) begin
        pend_reg <= 1'b0;
        asgd_reg <= 1'b0;
      end else if (accept && off_slot_reg == SB'(gi)) begin
        pend_reg <= 1'b0;
        asgd_reg <= 1'b1;
      end else if (press && !pend_reg && !asgd_reg) begin
        pend_reg <= 1'b1;
      end
    end

    assign pend_vec[gi]   = pend_reg;
    assign asgd_vec[gi]   = asgd_reg;
    assign served_hit[gi] = hit;
  end

  assign lamp_up   = pend_vec[FLOORS-1:0]  | asgd_vec[FLOORS-1:0];
  assign lamp_down = pend_vec[NS-1:FLOORS] | asgd_vec[NS-1:FLOORS];

  // A slot being cleared this cycle is not worth offering.
  assign cand = pend_vec & ~served_hit;

  always_comb begin
    found     = 1'b0;
    scan_slot = '0;
    idx       = '0;
    sum       = '0;
    for (int k = 0; k < NS; k++) begin
      sum = {1'b0, ptr_reg} + (SB+1)'(k);
      if (sum >= (SB+1)'(NS))
        sum = sum - (SB+1)'(NS);
      idx = sum[SB-1:0];
      if (!found && cand[idx]) begin
        found     = 1'b1;
        scan_slot = idx;
      end
    end
  end

  always_comb begin
    scan_floor = FB'((scan_slot >= SB'(FLOORS)) ? scan_slot - SB'(FLOORS) : scan_slot);
    loc0  = {1'b0, car_loc[0  +: FB]};
    loc1  = {1'b0, car_loc[FB +: FB]};
    tgt   = {1'b0, scan_floor};
    dist0 = (loc0 > tgt) ? loc0 - tgt : tgt - loc0;
    dist1 = (loc1 > tgt) ? loc1 - tgt : tgt - loc1;
    pick_car = 1'b0;
    if (car_idle[0] && car_idle[1]) begin
      if (dist0 < dist1)      pick_car = 1'b0;
      else if (dist1 < dist0) pick_car = 1'b1;
      else                    pick_car = rr_reg;
    end else begin
      pick_car = car_idle[1];
    end
  end

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      SCAN: begin
        if (found && |car_idle) begin
          latch      = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (served_hit[off_slot_reg]) begin
          state_next = SCAN;
        end else if (asg_ready) begin
          accept     = 1'b1;
          state_next = SCAN;
        end else if (!car_idle[asg_car_reg]) begin
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SCAN;
      ptr_reg      <= '0;
      rr_reg       <= 1'b0;
      off_slot_reg <= '0;
      asg_car_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        off_slot_reg <= scan_slot;
        asg_car_reg  <= pick_car;
      end
      if (accept) begin
        ptr_reg <= (off_slot_reg == SB'(NS - 1)) ? '0 : off_slot_reg + SB'(1);
        rr_reg  <= ~rr_reg;
      end
    end
  end

  assign asg_valid = (state_reg == OFFER);
  assign asg_car   = asg_car_reg;
  assign asg_floor = FB'((off_slot_reg >= SB'(FLOORS)) ? off_slot_reg - SB'(FLOORS) : off_slot_reg);
  assign asg_dir   = (off_slot_reg >= SB'(FLOORS));

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher; expected offers are queued by the
// stimulus and checked by an independent monitor when asg_valid rises.
module tb_hall_call_dispatcher;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hall_up, hall_down;
  logic [3:0] car_loc;
  logic [1:0] car_idle, served_valid, served_dir;
  logic [3:0] served_floor;
  logic       asg_valid, asg_car, asg_dir, asg_ready;
  logic [1:0] asg_floor;
  logic [3:0] lamp_up, lamp_down;

  int checks = 0;
  int fails  = 0;
  logic [3:0] exp_q[$];   // {car, floor[1:0], dir}

  always #5 clk = ~clk;

  hall_call_dispatcher #(.FLOORS(4), .CARS(2)) dut (
    .clk(clk), .reset(reset), .hall_up(hall_up), .hall_down(hall_down),
    .car_loc(car_loc), .car_idle(car_idle), .served_valid(served_valid),
    .served_floor(served_floor), .served_dir(served_dir),
    .asg_valid(asg_valid), .asg_car(asg_car), .asg_floor(asg_floor),
    .asg_dir(asg_dir), .asg_ready(asg_ready),
    .lamp_up(lamp_up), .lamp_down(lamp_down)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] up, input logic [3:0] dn);
    hall_up   = up;
    hall_down = dn;
    tick();
    hall_up   = '0;
    hall_down = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hall_up = '0; hall_down = '0; served_valid = '0; asg_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (asg_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got no offer within %0d cycles, expected asg_valid=1", name, max);
    end
  endtask

  task automatic accept_offer(input string name);
    bit ok;
    wait_valid(name, 6, ok);
    if (ok) begin
      asg_ready = 1'b1;
      tick();
      asg_ready = 1'b0;
      chk({name, " drop"}, asg_valid, 0);
    end
  endtask

  // Monitor: pops one expectation per offer and checks the offer holds steady.
  initial begin
    logic       prev_v;
    logic [3:0] got, held;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      got = {asg_car, asg_floor, asg_dir};
      if (asg_valid && !prev_v) begin
        $display("offer car=%0d floor=%0d dir=%0d", asg_car, asg_floor, asg_dir);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected offer: got %0h, expected none", got);
        end else begin
          chk("offer content", got, exp_q.pop_front());
        end
        held = got;
      end else if (asg_valid && prev_v) begin
        chk("offer stable", got, held);
      end
      prev_v = asg_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok, bad;
    reset = 1'b1; hall_up = 4'b0010; hall_down = '0;
    car_loc = 4'b1100; car_idle = 2'b11;
    served_valid = '0; served_floor = '0; served_dir = '0; asg_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset asg_valid", asg_valid, 0);
    chk("reset asg_car/floor/dir", {asg_car, asg_floor, asg_dir}, 0);
    chk("reset lamps", {lamp_up, lamp_down}, 0);
    reset = 1'b0; hall_up = '0;
    tick();
    chk("press during reset ignored", lamp_up, 0);

    // Nearest car, latency n+2, acceptance keeps the lamp lit.
    exp_q.push_back(4'b0010);
    press(4'b0010, 4'b0000);
    chk("s1 lamp at n+1", lamp_up, 4'b0010);
    chk("s1 no offer at n+1", asg_valid, 0);
    tick();
    chk("s1 offer at n+2", asg_valid, 1);
    tick();
    asg_ready = 1'b1;
    tick();
    asg_ready = 1'b0;
    chk("s1 valid drop n+4", asg_valid, 0);
    chk("s1 lamp assigned", lamp_up, 4'b0010);
    served_valid = 2'b01; served_floor = 4'b0001; served_dir = 2'b00;
    tick();
    served_valid = '0;
    chk("s1 served clears lamp", lamp_up, 0);

    // Tie broken by the rotating priority.
    do_reset();
    car_loc = 4'b1010;
    exp_q.push_back(4'b0111);
    press(4'b0000, 4'b1000);
    accept_offer("s2a");
    exp_q.push_back(4'b1011);
    press(4'b0000, 4'b0010);
    accept_offer("s2b");
    chk("s2 lamps down", lamp_down, 4'b1010);

    // Non-existent up at top / down at bottom.
    do_reset();
    bad = 1'b0;
    press(4'b1000, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      if (lamp_up != 0 || lamp_down != 0 || asg_valid) bad = 1'b1;
      tick();
    end
    chk("s3 invalid slots ignored", bad, 0);

    // Scan order from ptr=0, then from ptr=2.
    do_reset();
    car_loc = 4'b1100;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1100);
    press(4'b0101, 4'b0000);
    accept_offer("s4 ptr0 first");
    accept_offer("s4 ptr0 second");
    do_reset();
    exp_q.push_back(4'b0010);
    press(4'b0010, 4'b0000);
    accept_offer("s4 set ptr2");
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0000);
    press(4'b0101, 4'b0000);
    accept_offer("s4 ptr2 first");
    accept_offer("s4 ptr2 second");

    // Served during the offer withdraws it even with asg_ready high.
    do_reset();
    exp_q.push_back(4'b0010);
    press(4'b0010, 4'b0000);
    wait_valid("s5 offer", 6, ok);
    served_valid = 2'b10; served_floor = 4'b0100; served_dir = 2'b00; asg_ready = 1'b1;
    tick();
    served_valid = '0; asg_ready = 1'b0;
    chk("s5 withdrawn", asg_valid, 0);
    chk("s5 lamp off", lamp_up, 0);
    hall_up = 4'b0100; served_valid = 2'b01; served_floor = 4'b0010;
    tick();
    hall_up = '0; served_valid = '0;
    chk("s5 served beats press", lamp_up, 0);
    repeat (4) tick();
    chk("s5 no later offer", asg_valid, 0);

    // No idle car, then one becomes idle; async reset mid-offer.
    do_reset();
    car_idle = 2'b00;
    press(4'b0011, 4'b0100);
    chk("s6 lamps pending", {lamp_up, lamp_down}, 8'b0011_0100);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (asg_valid) bad = 1'b1;
      tick();
    end
    chk("s6 no offer without idle car", bad, 0);
    exp_q.push_back(4'b1000);
    car_idle = 2'b10;
    wait_valid("s6 offer after idle", 3, ok);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("s6 async reset valid", asg_valid, 0);
    chk("s6 async reset car/floor/dir", {asg_car, asg_floor, asg_dir}, 0);
    chk("s6 async reset lamps", {lamp_up, lamp_down}, 0);
    tick();
    reset = 1'b0; car_idle = 2'b11;
    repeat (2) tick();
    chk("s6 after reset idle", {asg_valid, lamp_up, lamp_down}, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
